// File: rtl/pipe_hazard_arbiter.sv
// Prioritised stall/flush arbiter for the in-order pipeline.
// Handles the post-reset flush window, deferred flushes and event counters.
module pipe_hazard_arbiter #(
  parameter int STAGES = 6,
  parameter int NREQ = 4,
  parameter logic [NREQ*STAGES-1:0] STALL_MASKS = 24'h7C2087,
  parameter logic [NREQ*STAGES-1:0] FLUSH_MASKS = 24'h80E388,
  parameter logic [NREQ-1:0] DEFER_MASK = 4'b0110,
  parameter int RST_FLUSH_CYCLES = 2,
  parameter int CNT_W = 32,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  output logic [STAGES-1:0] stall_o,
  output logic [STAGES-1:0] flush_o,
  output logic              active_valid_o,
  output logic [IDW-1:0]    active_id_o,
  output logic [NREQ-1:0]   pend_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam int WW =
    (RST_FLUSH_CYCLES > 0) ? $clog2(RST_FLUSH_CYCLES + 1) : 1;

  logic [WW-1:0]     win_q;
  logic [NREQ-1:0]   pend_q;
  logic [NREQ-1:0]   pend_nxt;
  logic [NREQ-1:0]   eff;
  logic              hit;
  logic [IDW-1:0]    win;
  logic [STAGES-1:0] wstall;
  logic [STAGES-1:0] wflush;
  logic              hold;

  assign hold   = rst || (win_q != '0);
  assign pend_o = pend_q;

  // Highest-index effective request wins; later loop hits override.
  always_comb begin
    eff    = req_i | pend_q;
    hit    = 1'b0;
    win    = '0;
    wstall = '0;
    wflush = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (eff[i]) begin
        hit    = 1'b1;
        win    = IDW'(i);
        wstall = STALL_MASKS[i*STAGES +: STAGES];
        wflush = FLUSH_MASKS[i*STAGES +: STAGES];
      end
    end
  end

  // Drive stage enables; reset and the window force an all-stage flush.
  always_comb begin
    stall_o        = '0;
    flush_o        = '0;
    active_valid_o = 1'b0;
    active_id_o    = '0;
    if (hold) begin
      flush_o = '1;
    end else if (hit) begin
      stall_o        = wstall;
      flush_o        = wflush;
      active_valid_o = 1'b1;
      active_id_o    = win;
    end
  end

  // Winner clears its pending bit; deferrable losers get latched.
  always_comb begin
    pend_nxt = pend_q;
    for (int i = 0; i < NREQ; i++) begin
      if (hit && (win == IDW'(i))) begin
        pend_nxt[i] = 1'b0;
      end else if (req_i[i] && DEFER_MASK[i]) begin
        pend_nxt[i] = 1'b1;
      end
    end
    if (hold) begin
      pend_nxt = '0;
    end
  end

  // Window countdown, pending state and saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q       <= WW'(RST_FLUSH_CYCLES);
      pend_q      <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      pend_q <= pend_nxt;
      if (win_q != '0) begin
        win_q <= win_q - WW'(1);
      end else begin
        if ((stall_o != '0) && (stall_cnt_o != '1)) begin
          stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
        if ((flush_o != '0) && (flush_cnt_o != '1)) begin
          flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_arbiter.sv
// Randomised and directed bench for pipe_hazard_arbiter.
// Two instances: default counters and 4-bit saturating counters.
module tb_pipe_hazard_arbiter;

  localparam int RFC = 2;
  localparam logic [23:0] SM = 24'h7C2087;
  localparam logic [23:0] FM = 24'h80E388;
  localparam logic [3:0]  DM = 4'b0110;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;

  logic [5:0]  a_stall, a_flush, b_stall, b_flush;
  logic        a_valid, b_valid;
  logic [1:0]  a_id, b_id;
  logic [3:0]  a_pend, b_pend;
  logic [31:0] a_scnt, a_fcnt;
  logic [3:0]  b_scnt, b_fcnt;

  int n_tests = 0;
  int n_fail  = 0;

  bit     m_pend [4];
  int     since_rst;
  longint scnt, fcnt;

  always #5 clk = ~clk;

  pipe_hazard_arbiter ua (
    .clk(clk), .rst(rst), .req_i(req),
    .stall_o(a_stall), .flush_o(a_flush),
    .active_valid_o(a_valid), .active_id_o(a_id),
    .pend_o(a_pend),
    .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt)
  );

  pipe_hazard_arbiter #(.CNT_W(4)) ub (
    .clk(clk), .rst(rst), .req_i(req),
    .stall_o(b_stall), .flush_o(b_flush),
    .active_valid_o(b_valid), .active_id_o(b_id),
    .pend_o(b_pend),
    .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat15(longint v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic step(input logic [3:0] r, input logic rs);
    int         w;
    bit         inr;
    logic [5:0] es, ef;
    logic [3:0] ep;
    req = r;
    rst = rs;
    #2;
    inr = rs || (since_rst < RFC);
    w = -1;
    if (!inr) begin
      for (int i = 3; i >= 0; i--) begin
        if (w < 0 && (r[i] || m_pend[i])) w = i;
      end
    end
    es = '0;
    ef = '0;
    if (inr) begin
      ef = 6'h3F;
    end else if (w >= 0) begin
      es = SM[w*6 +: 6];
      ef = FM[w*6 +: 6];
    end
    for (int i = 0; i < 4; i++) ep[i] = m_pend[i];
    chk("stall", a_stall, es);
    chk("flush", a_flush, ef);
    chk("valid", a_valid, (w >= 0));
    chk("id", a_id, (w >= 0) ? w : 0);
    chk("pend", a_pend, ep);
    chk("scnt", a_scnt, scnt);
    chk("fcnt", a_fcnt, fcnt);
    chk("b_stall", b_stall, es);
    chk("b_pend", b_pend, ep);
    chk("b_scnt", b_scnt, sat15(scnt));
    chk("b_fcnt", b_fcnt, sat15(fcnt));
    @(posedge clk);
    if (rs) begin
      since_rst = 0;
      for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
      scnt = 0;
      fcnt = 0;
    end else begin
      if (!inr) begin
        for (int i = 0; i < 4; i++) begin
          if (i == w) m_pend[i] = 1'b0;
          else if (r[i] && DM[i]) m_pend[i] = 1'b1;
        end
        if (es != 0) scnt++;
        if (ef != 0) fcnt++;
      end
      if (since_rst < 1000) since_rst++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    since_rst = 0;
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    scnt = 0;
    fcnt = 0;

    // reset window then all requests
    repeat (3) step(4'b0000, 1'b1);
    repeat (5) step(4'b1111, 1'b0);
    step(4'b0000, 1'b0);

    // single request, fresh counters
    step(4'b0000, 1'b1);
    repeat (2) step(4'b0000, 1'b0);
    repeat (3) step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);

    // deferral
    step(4'b1010, 1'b0);
    repeat (2) step(4'b0000, 1'b0);

    // long stall covering a trap
    step(4'b1000, 1'b0);
    step(4'b1100, 1'b0);
    repeat (3) step(4'b1000, 1'b0);
    repeat (2) step(4'b0000, 1'b0);

    // non-deferrable loss
    step(4'b1001, 1'b0);
    step(4'b0000, 1'b0);

    // saturation, then reset with a pending bit
    repeat (20) step(4'b0001, 1'b0);
    step(4'b1100, 1'b0);
    step(4'b0000, 1'b1);
    repeat (4) step(4'b0000, 1'b0);

    // request arriving in the final window cycle
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    repeat (2) step(4'b0000, 1'b0);

    // random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      step(4'($urandom) & 4'($urandom),
           ($urandom_range(0, 39) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_arbiter.md
# pipe_hazard_arbiter

Parametrised stall/flush arbiter for the in-order pipeline. It generalises the fixed hazard controller to `STAGES` pipeline registers and `NREQ` prioritised hazard sources, each with its own stall/flush masks supplied as parameters. It adds sequential behaviour: a multi-cycle post-reset flush window, deferral of flush requests that lose arbitration so they are never dropped, and saturating stall/flush event counters. It sits beside the pipeline registers and drives their per-stage stall and flush enables.

## Interface
- `STAGES`, 6: number of pipeline registers. Bit 0 is PC; higher bits are later stages.
- `NREQ`, 4: number of hazard request sources. Higher index means higher priority.
- `STALL_MASKS`, 24'h7C2087: `NREQ*STAGES` bits. The stall mask of request i is `[i*STAGES +: STAGES]`.
- `FLUSH_MASKS`, 24'h80E388: `NREQ*STAGES` bits, same packing as `STALL_MASKS`.
- `DEFER_MASK`, 4'b0110: one bit per request. When set, a losing request is latched as pending.
- `RST_FLUSH_CYCLES`, 2: number of all-flush cycles after `rst` deasserts. 0 is legal.
- `CNT_W`, 32: width of the event counters.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_i` input NREQ: level hazard requests.
- `stall_o` output STAGES: stall enables.
- `flush_o` output STAGES: flush enables.
- `active_valid_o` output 1: a request won in this cycle.
- `active_id_o` output max(1,$clog2(NREQ)): index of the winning request.
- `pend_o` output NREQ: current pending-deferred bits.
- `stall_cnt_o` output CNT_W: number of cycles with `stall_o != 0`.
- `flush_cnt_o` output CNT_W: number of cycles with `flush_o != 0`, excluding reset and the post-reset window.

## Operation
- **Effective request:** `eff = req_i | pend_q`.
- **Winner:** the highest set index of `eff`.
- **Outputs while a winner exists:**
  - `stall_o` and `flush_o` are the winner's masks.
  - `active_valid_o = 1` and `active_id_o` is the winner index.
- **Outputs with no effective request:** stall 0, flush 0, `active_valid_o = 0`, `active_id_o = 0`.
- **Reset state** (`rst` high, and while the window counter `win_q != 0`):
  - `stall_o = 0`, `flush_o` all ones, `active_valid_o = 0`.
  - `req_i` is ignored.
  - `pend_q` is forced to 0.
  - Counters hold, and are forced to 0 while `rst` is high.
- **Window counter:**
  - `rst` loads `win_q = RST_FLUSH_CYCLES`.
  - Outside reset, `win_q` decrements toward 0 each cycle.
- **Pending set:** at each edge outside reset/window, for each i, `pend_q[i]` is set when all of the following hold:
  - `req_i[i]`
  - `DEFER_MASK[i]`
  - i is not the winner
- **Pending clear:** `pend_q[i]` is cleared on any edge where i is the winner, whether it won via `req_i` or via `pend_q`.
- **Pending hold:** a pending bit that is still losing stays set. A re-assertion of `req_i[i]` while pending merges into the same single event.
- Requests without their `DEFER_MASK` bit set are never latched. They are simply dropped while losing.
- **Counters:** each increments by 1 per qualifying cycle and saturates at all ones. They never wrap.

## Timing
- `stall_o`, `flush_o`, `active_*`: combinational from `req_i`, `pend_q`, `rst`, and `win_q`. There is zero-cycle latency from a request to its masks.
- `pend_o = pend_q` is registered. A deferred request takes effect at the earliest cycle after it loses in which it is the winner.
- **Deferred-request cycle rule:** a deferred request is serviced for exactly one cycle unless its source keeps `req_i` asserted.
- **Reset values:**
  - `stall_o` 0, `flush_o` all ones, `active_valid_o` 0, `active_id_o` 0.
  - `pend_o` 0, both counters 0.
- The reset state lasts for every `rst`-high cycle plus `RST_FLUSH_CYCLES` cycles after `rst` drops.
- **Reset mid-operation:** `rst` asserted mid-operation discards pending bits that same edge. Counters are 0 after the edge.
- A deferrable request that arrives in the final window cycle is not latched.
- **Simultaneous win and re-request:** if the winner is pending and `req_i` of the same index is also high, the bit clears. The request is then serviced normally if it is still high next cycle.

## Test plan
- **Reset window:** hold `rst` 3 cycles, then release with `req_i = 4'b1111`.
  - Expect `flush_o = 6'h3F`, `stall_o = 0` for 5 cycles.
  - Then expect mem masks `011111/100000`.
  - Counters are 0 at the first post-window cycle.
- **Single request:** `req_i = 4'b0001` for 3 cycles.
  - Expect `stall_o = 6'b000111`, `flush_o = 6'b001000` in the same cycles and `active_id_o = 0`.
  - Expect `stall_cnt_o = 3` and `flush_cnt_o = 3`.
- **Deferral:** `req_i = 4'b1010` for one cycle, then `4'b0000`.
  - Cycle 0: mem masks, and `pend_o = 4'b0010` after the edge.
  - Cycle 1: `stall_o = 000010`, `flush_o = 001110`, `active_id_o = 1`.
  - Cycle 2: `pend_o = 0` and outputs are 0.
- **Long stall covering a trap:** `req_i[3]` high for 5 cycles, with a `req_i[2]` pulse at cycle 1.
  - `pend_o[2]` is set from cycle 2 to cycle 5.
  - Trap masks appear exactly once, at cycle 5.
- **Non-deferrable loss:** `req_i = 4'b1001` for one cycle, then 0.
  - `pend_o` stays 0 and there are no outputs in the next cycle.
- **Saturation and reset mid-pending:** with `CNT_W = 4`, hold `req_i[0]` for 20 cycles.
  - `stall_cnt_o` stops at 15.
  - Then create a pending bit and assert `rst`: `pend_o` and the counters are 0 after the edge.
